// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq
//
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One DATA_W-bit unsigned value is converted per transaction, one bit per
// clock. The result appears DATA_W cycles after the accepting edge. If the
// value needs more than DIGITS decimal digits, the result saturates to all
// nines and out_ovf is raised.
//
// Ports:
//   sys_clk      rising-edge clock
//   sys_rst_n    synchronous active-low reset
//   in_valid     in_data holds a value to convert
//   in_ready     converter is idle and will accept in_data
//   in_data      unsigned binary value (DATA_W bits)
//   out_valid    out_bcd / out_ndigits / out_ovf hold a finished result
//   out_ready    downstream takes the result
//   out_bcd      packed BCD, digit 0 (units) in bits [3:0]
//   out_ndigits  count of significant digits, 1..DIGITS
//   out_ovf      value did not fit in DIGITS digits
module binary_to_bcd_seq #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [4*DIGITS-1:0]            out_bcd,
    output logic [$clog2(DIGITS+1)-1:0]    out_ndigits,
    output logic                           out_ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int NDW   = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [SR_W-1:0]   sr_q;        // {BCD field, binary field}
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;       // sticky: a 1 has left the top of the BCD field

    logic [BCD_W-1:0]  bcd_adj;
    logic [SR_W-1:0]   sr_shift;
    logic [BCD_W-1:0]  bcd_next;
    logic              ovf_next;
    logic              last_iter;

    // Add 3 to every digit above 4 so the following shift carries correctly.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] > 4'd4)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Saturated result: every digit 9.
    function automatic logic [BCD_W-1:0] sat_bcd();
        logic [BCD_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++)
            r[4*i +: 4] = 4'd9;
        return r;
    endfunction

    // Index of the highest nonzero digit plus one; zero still counts as one digit.
    function automatic logic [NDW-1:0] count_digits(input logic [BCD_W-1:0] b);
        logic [NDW-1:0] r;
        r = NDW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] != 4'd0)
                r = NDW'(i + 1);
        end
        return r;
    endfunction

    // One double-dabble iteration; the BCD MSB drops off the top of the shift.
    assign bcd_adj   = add3(sr_q[SR_W-1 -: BCD_W]);
    assign sr_shift  = {bcd_adj, sr_q[DATA_W-1:0]} << 1;
    assign bcd_next  = sr_shift[SR_W-1 -: BCD_W];
    assign ovf_next  = ovf_q | bcd_adj[BCD_W-1];
    assign last_iter = (cnt_q == CNT_W'(1));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CONV;
            CONV:    if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_bcd     <= '0;
            out_ndigits <= NDW'(1);
            out_ovf     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sr_q  <= {{BCD_W{1'b0}}, in_data};
                        cnt_q <= CNT_W'(DATA_W);
                        ovf_q <= 1'b0;
                    end
                end
                CONV: begin
                    sr_q  <= sr_shift;
                    cnt_q <= cnt_q - CNT_W'(1);
                    ovf_q <= ovf_next;
                    // Result is registered on the final iteration edge.
                    if (last_iter) begin
                        if (ovf_next) begin
                            out_bcd     <= sat_bcd();
                            out_ndigits <= NDW'(DIGITS);
                            out_ovf     <= 1'b1;
                        end else begin
                            out_bcd     <= bcd_next;
                            out_ndigits <= count_digits(bcd_next);
                            out_ovf     <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb_binary_to_bcd_seq
//
// Bench for binary_to_bcd_seq. Three instances share clock and reset:
//   dut 0: DATA_W=8,  DIGITS=3
//   dut 1: DATA_W=16, DIGITS=5
//   dut 2: DATA_W=8,  DIGITS=2 (overflow possible)
// Expected results come from a decimal model built on integer division.
module tb_binary_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic [2:0]  iv;
    logic [2:0]  irdy;
    logic [2:0]  ovld;
    logic [2:0]  ordy;
    logic [2:0]  ovf3;
    logic [7:0]  din_a;
    logic [15:0] din_b;
    logic [7:0]  din_c;
    logic [11:0] bcd_a;
    logic [19:0] bcd_b;
    logic [7:0]  bcd_c;
    logic [1:0]  nd_a;
    logic [2:0]  nd_b;
    logic [1:0]  nd_c;

    int n_chk  = 0;
    int n_fail = 0;

    int dw[3] = '{8, 16, 8};
    int dg[3] = '{3, 5, 2};

    binary_to_bcd_seq #(.DATA_W(8), .DIGITS(3)) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .in_data(din_a), .out_valid(ovld[0]), .out_ready(ordy[0]),
        .out_bcd(bcd_a), .out_ndigits(nd_a), .out_ovf(ovf3[0]));

    binary_to_bcd_seq #(.DATA_W(16), .DIGITS(5)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .in_data(din_b), .out_valid(ovld[1]), .out_ready(ordy[1]),
        .out_bcd(bcd_b), .out_ndigits(nd_b), .out_ovf(ovf3[1]));

    binary_to_bcd_seq #(.DATA_W(8), .DIGITS(2)) u_c (
        .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .in_data(din_c), .out_valid(ovld[2]), .out_ready(ordy[2]),
        .out_bcd(bcd_c), .out_ndigits(nd_c), .out_ovf(ovf3[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference model
    function automatic logic [19:0] ref_bcd(input int unsigned v, input int d);
        logic [19:0] r;
        longint      lim;
        int unsigned t;
        r = '0;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        t = v;
        for (int i = 0; i < d; i++) begin
            if (longint'(v) >= lim) r[4*i +: 4] = 4'd9;
            else begin
                r[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v, input int d);
        longint lim;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        return longint'(v) >= lim;
    endfunction

    function automatic int ref_nd(input int unsigned v, input int d);
        int n;
        int unsigned t;
        if (ref_ovf(v, d)) return d;
        n = 1;
        t = v / 10;
        while (t > 0) begin
            n++;
            t = t / 10;
        end
        return n;
    endfunction

    function automatic logic [19:0] get_bcd(input int k);
        case (k)
            0:       return {8'h0, bcd_a};
            1:       return bcd_b;
            default: return {12'h0, bcd_c};
        endcase
    endfunction

    function automatic int get_nd(input int k);
        case (k)
            0:       return int'(nd_a);
            1:       return int'(nd_b);
            default: return int'(nd_c);
        endcase
    endfunction

    task automatic set_din(input int k, input logic [15:0] v);
        case (k)
            0:       din_a = v[7:0];
            1:       din_b = v;
            default: din_c = v[7:0];
        endcase
    endtask

    // One full transaction; returns what was on the outputs while out_valid was high.
    task automatic convert(input int k, input logic [15:0] v, input int stall,
                           output logic [19:0] bcd, output int nd, output logic ovf,
                           output int lat);
        int t;
        t = 0;
        while (!irdy[k] && t < 100) begin
            @(posedge clk); #1; t++;
        end
        n_chk++;
        if (!irdy[k]) begin
            n_fail++;
            $display("FAIL ready_timeout dut%0d: in_ready=%b required 1", k, irdy[k]);
        end
        set_din(k, v);
        iv[k] = 1'b1;
        @(posedge clk); #1;
        iv[k] = 1'b0;
        lat = 0;
        while (!ovld[k] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        n_chk++;
        if (!ovld[k]) begin
            n_fail++;
            $display("FAIL valid_timeout dut%0d: out_valid=%b required 1", k, ovld[k]);
        end
        bcd = get_bcd(k);
        nd  = get_nd(k);
        ovf = ovf3[k];
        repeat (stall) begin
            @(posedge clk); #1;
        end
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (irdy[k] !== 1'b1 || ovld[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hs dut%0d: in_ready=%b out_valid=%b required 1 0", k, irdy[k], ovld[k]);
            end
            n_chk++;
            if (get_bcd(k) !== 20'h0 || get_nd(k) != 1 || ovf3[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_out dut%0d: bcd=%h nd=%0d ovf=%b required 0 1 0", k, get_bcd(k), get_nd(k), ovf3[k]);
            end
        end
    endtask

    typedef struct {
        int          k;
        int          v;
        logic [19:0] bcd;
        int          nd;
        logic        ovf;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[10] = '{
            '{0, 255,   20'h00255, 3, 1'b0},
            '{0, 0,     20'h00000, 1, 1'b0},
            '{0, 7,     20'h00007, 1, 1'b0},
            '{0, 10,    20'h00010, 2, 1'b0},
            '{1, 65535, 20'h65535, 5, 1'b0},
            '{1, 10000, 20'h10000, 5, 1'b0},
            '{1, 9999,  20'h09999, 4, 1'b0},
            '{2, 99,    20'h00099, 2, 1'b0},
            '{2, 100,   20'h00099, 2, 1'b1},
            '{2, 255,   20'h00099, 2, 1'b1}
        };
        logic [19:0] bcd;
        int nd, lat;
        logic ovf;
        foreach (tbl[i]) begin
            convert(tbl[i].k, 16'(tbl[i].v), 0, bcd, nd, ovf, lat);
            n_chk++;
            if (bcd !== tbl[i].bcd || nd != tbl[i].nd || ovf !== tbl[i].ovf) begin
                n_fail++;
                $display("FAIL directed dut%0d v=%0d: bcd=%h nd=%0d ovf=%b required %h %0d %b",
                         tbl[i].k, tbl[i].v, bcd, nd, ovf, tbl[i].bcd, tbl[i].nd, tbl[i].ovf);
            end
            n_chk++;
            if (lat != dw[tbl[i].k]) begin
                n_fail++;
                $display("FAIL latency dut%0d v=%0d: cycles=%0d required %0d", tbl[i].k, tbl[i].v, lat, dw[tbl[i].k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [19:0] snap_bcd;
        int snap_nd, t;
        logic snap_ovf;
        t = 0;
        while (!irdy[0] && t < 100) begin
            @(posedge clk); #1; t++;
        end
        din_a = 8'd123;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        t = 0;
        while (!ovld[0] && t < 100) begin
            @(posedge clk); #1; t++;
        end
        snap_bcd = get_bcd(0);
        snap_nd  = get_nd(0);
        snap_ovf = ovf3[0];
        n_chk++;
        if (snap_bcd !== ref_bcd(123, 3) || snap_nd != ref_nd(123, 3) || snap_ovf !== 1'b0 || ovld[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_result: valid=%b bcd=%h nd=%0d ovf=%b required 1 %h %0d 0",
                     ovld[0], snap_bcd, snap_nd, snap_ovf, ref_bcd(123, 3), ref_nd(123, 3));
        end
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'($urandom_range(0, 1));
            din_a = 8'($urandom);
            @(posedge clk); #1;
            n_chk++;
            if (get_bcd(0) !== snap_bcd || get_nd(0) != snap_nd || ovf3[0] !== snap_ovf ||
                ovld[0] !== 1'b1 || irdy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle%0d: valid=%b ready=%b bcd=%h nd=%0d required 1 0 %h %0d",
                         i, ovld[0], irdy[0], get_bcd(0), get_nd(0), snap_bcd, snap_nd);
            end
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        n_chk++;
        if (ovld[0] !== 1'b0 || irdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b required 0 1", ovld[0], irdy[0]);
        end
        n_chk++;
        if (get_bcd(0) !== snap_bcd || get_nd(0) != snap_nd) begin
            n_fail++;
            $display("FAIL bp_retain: bcd=%h nd=%0d required %h %0d", get_bcd(0), get_nd(0), snap_bcd, snap_nd);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] bcd;
        int nd, lat;
        logic ovf;
        din_a = 8'd200;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_chk++;
        if (irdy[0] !== 1'b1 || ovld[0] !== 1'b0 || get_bcd(0) !== 20'h0 || get_nd(0) != 1 || ovf3[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: ready=%b valid=%b bcd=%h nd=%0d ovf=%b required 1 0 0 1 0",
                     irdy[0], ovld[0], get_bcd(0), get_nd(0), ovf3[0]);
        end
        repeat (10) begin
            @(posedge clk); #1;
        end
        n_chk++;
        if (ovld[0] !== 1'b0 || irdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_discard: valid=%b ready=%b required 0 1", ovld[0], irdy[0]);
        end
        convert(0, 16'd42, 1, bcd, nd, ovf, lat);
        n_chk++;
        if (bcd !== 20'h00042 || nd != 2 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after: bcd=%h nd=%0d ovf=%b required 00042 2 0", bcd, nd, ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] e;
        int last_v;
        last_v = -1;
        ordy[0] = 1'b1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            iv[0] = (cyc < 50);
            din_a = 8'($urandom);
            if (irdy[0] && iv[0]) q.push_back(din_a);
            @(posedge clk); #1;
            if (ovld[0]) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra cycle%0d: unexpected result bcd=%h", cyc, get_bcd(0));
                end else begin
                    e = q.pop_front();
                    if (get_bcd(0) !== ref_bcd(e, 3) || get_nd(0) != ref_nd(e, 3)) begin
                        n_fail++;
                        $display("FAIL b2b_data v=%0d: bcd=%h nd=%0d required %h %0d",
                                 e, get_bcd(0), get_nd(0), ref_bcd(e, 3), ref_nd(e, 3));
                    end
                end
                if (last_v >= 0) begin
                    n_chk++;
                    if (cyc - last_v != 10) begin
                        n_fail++;
                        $display("FAIL b2b_rate: spacing=%0d required 10", cyc - last_v);
                    end
                end
                last_v = cyc;
            end
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b0;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: pending=%0d required 0", q.size());
        end
    endtask

    task automatic test_exhaustive();
        logic [19:0] bcd;
        int nd, lat;
        logic ovf;
        int unsigned v;
        for (int i = 0; i < 256; i++) begin
            convert(0, 16'(i), int'($urandom_range(0, 3)), bcd, nd, ovf, lat);
            n_chk++;
            if (bcd !== ref_bcd(i, 3) || nd != ref_nd(i, 3) || ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL exh8 v=%0d: bcd=%h nd=%0d ovf=%b required %h %0d 0",
                         i, bcd, nd, ovf, ref_bcd(i, 3), ref_nd(i, 3));
            end
        end
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, 65535);
            convert(1, 16'(v), int'($urandom_range(0, 2)), bcd, nd, ovf, lat);
            n_chk++;
            if (bcd !== ref_bcd(v, 5) || nd != ref_nd(v, 5) || ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd16 v=%0d: bcd=%h nd=%0d ovf=%b required %h %0d 0",
                         v, bcd, nd, ovf, ref_bcd(v, 5), ref_nd(v, 5));
            end
        end
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, 255);
            convert(2, 16'(v), int'($urandom_range(0, 2)), bcd, nd, ovf, lat);
            n_chk++;
            if (bcd !== ref_bcd(v, 2) || nd != ref_nd(v, 2) || ovf !== ref_ovf(v, 2)) begin
                n_fail++;
                $display("FAIL rnd8d2 v=%0d: bcd=%h nd=%0d ovf=%b required %h %0d %b",
                         v, bcd, nd, ovf, ref_bcd(v, 2), ref_nd(v, 2), ref_ovf(v, 2));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iv    = '0;
        ordy  = '0;
        din_a = '0;
        din_b = '0;
        din_c = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
